// File: rtl/fetch_db_ext_mem_pkg.sv
// Shared constants for the deblocking fetch ext-memory responder:
// load/store mode encodings, store buffer address map and plane bases.
package fetch_db_ext_mem_pkg;

    localparam logic [1:0] MODE_Y_BOT   = 2'b00;
    localparam logic [1:0] MODE_Y_FULL  = 2'b01;
    localparam logic [1:0] MODE_UV_BOT  = 2'b10;
    localparam logic [1:0] MODE_UV_FULL = 2'b11;

    localparam logic [4:0] RADDR_Y_BASE  = 5'd0;
    localparam logic [4:0] RADDR_UV_BASE = 5'd16;

    localparam logic [23:0] Y_BASE_DEF = 24'h000000;
    localparam logic [23:0] U_BASE_DEF = 24'h100000;
    localparam logic [23:0] V_BASE_DEF = 24'h180000;

    function automatic logic [4:0] beat_count(input logic [1:0] mode);
        logic [4:0] n;
        case (mode)
            MODE_Y_BOT:  n = 5'd4;
            MODE_Y_FULL: n = 5'd16;
            MODE_UV_BOT: n = 5'd4;
            default:     n = 5'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fetch_db_ext_mem_addr_gen.sv
// Combinational map from (mode, beat k, MB position, picture width) to the
// frame-memory word address and the store-buffer read address.
module fetch_db_ext_addr_gen
    import fetch_db_ext_mem_pkg::*;
#(
    parameter int                PIC_W_MB_LEN = 8,
    parameter int                PIC_H_MB_LEN = 8,
    parameter int                ADDR_W       = 24,
    parameter logic [ADDR_W-1:0] Y_BASE       = ADDR_W'(Y_BASE_DEF),
    parameter logic [ADDR_W-1:0] U_BASE       = ADDR_W'(U_BASE_DEF),
    parameter logic [ADDR_W-1:0] V_BASE       = ADDR_W'(V_BASE_DEF)
) (
    input  logic [1:0]              mode_i,
    input  logic [3:0]              k_i,
    input  logic [PIC_W_MB_LEN-1:0] x_i,
    input  logic [PIC_H_MB_LEN-1:0] y_i,
    input  logic [PIC_W_MB_LEN:0]   w_i,
    output logic [ADDR_W-1:0]       addr_o,
    output logic [4:0]              raddr_o
);

    logic              is_luma;
    logic              plane_v;
    logic [1:0]        blk_r;
    logic [1:0]        blk_c;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] off;

    always_comb begin
        is_luma = ~mode_i[1];
        plane_v = 1'b0;
        blk_r   = 2'd0;
        blk_c   = 2'd0;
        raddr_o = RADDR_Y_BASE;
        case (mode_i)
            MODE_Y_BOT: begin
                blk_r   = 2'd3;
                blk_c   = k_i[1:0];
                raddr_o = RADDR_Y_BASE + 5'd12 + {3'b000, k_i[1:0]};
            end
            MODE_Y_FULL: begin
                blk_r   = k_i[3:2];
                blk_c   = k_i[1:0];
                raddr_o = RADDR_Y_BASE + {1'b0, k_i};
            end
            MODE_UV_BOT: begin
                // Chroma bottom line is block row 1 of each 8x8 plane.
                plane_v = k_i[1];
                blk_r   = 2'd1;
                blk_c   = {1'b0, k_i[0]};
                raddr_o = RADDR_UV_BASE + {2'b00, k_i[1], 1'b1, k_i[0]};
            end
            default: begin
                plane_v = k_i[2];
                blk_r   = {1'b0, k_i[1]};
                blk_c   = {1'b0, k_i[0]};
                raddr_o = RADDR_UV_BASE + {2'b00, k_i[2:0]};
            end
        endcase

        base = is_luma ? Y_BASE : (plane_v ? V_BASE : U_BASE);
        row  = is_luma ? ((ADDR_W'(y_i) << 2) + ADDR_W'(blk_r))
                       : ((ADDR_W'(y_i) << 1) + ADDR_W'(blk_r));
        off  = row * ADDR_W'(w_i) + ADDR_W'(x_i);
        addr_o = base + (is_luma ? (off << 2) : (off << 1)) + ADDR_W'(blk_c);
    end

endmodule

// File: rtl/fetch_db_ext_mem.sv
// Ext-memory responder for the deblocking fetch controller: serves load
// requests from frame memory and writes filtered blocks from the store buffer.
//   state     | meaning
//   IDLE      | wait for load_en_i / store_en_i, latch request
//   LD_REQ    | issue read k, gap cycle between words
//   LD_DONE   | load_done_o pulse
//   ST_RD     | store buffer read of word k
//   ST_CAP    | capture buffer data into write data
//   ST_REQ    | issue write k until ack
//   ST_DONE   | store_done_o pulse
module fetch_db_ext_mem
    import fetch_db_ext_mem_pkg::*;
#(
    parameter int                PIC_W_MB_LEN = 8,
    parameter int                PIC_H_MB_LEN = 8,
    parameter int                BIT_DEPTH    = 8,
    parameter int                ADDR_W       = 24,
    parameter logic [ADDR_W-1:0] Y_BASE       = ADDR_W'(Y_BASE_DEF),
    parameter logic [ADDR_W-1:0] U_BASE       = ADDR_W'(U_BASE_DEF),
    parameter logic [ADDR_W-1:0] V_BASE       = ADDR_W'(V_BASE_DEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIC_W_MB_LEN-1:0]   sys_total_x,
    input  logic                      load_en_i,
    input  logic [PIC_W_MB_LEN-1:0]   load_x_i,
    input  logic [PIC_H_MB_LEN-1:0]   load_y_i,
    input  logic [1:0]                load_mode_i,
    output logic                      load_done_o,
    output logic                      load_valid_o,
    output logic [16*BIT_DEPTH-1:0]   load_data_o,
    input  logic                      store_en_i,
    input  logic [PIC_W_MB_LEN-1:0]   store_x_i,
    input  logic [PIC_H_MB_LEN-1:0]   store_y_i,
    input  logic [1:0]                store_mode_i,
    output logic                      store_done_o,
    output logic                      store_rden_o,
    output logic [4:0]                store_raddr_o,
    input  logic [16*BIT_DEPTH-1:0]   store_rdata_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [16*BIT_DEPTH-1:0]   mem_wdata_o,
    input  logic                      mem_ack_i,
    input  logic [16*BIT_DEPTH-1:0]   mem_rdata_i
);

    localparam int DW = 16 * BIT_DEPTH;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LD_REQ  = 3'd1;
    localparam logic [2:0] S_LD_DONE = 3'd2;
    localparam logic [2:0] S_ST_RD   = 3'd3;
    localparam logic [2:0] S_ST_CAP  = 3'd4;
    localparam logic [2:0] S_ST_REQ  = 3'd5;
    localparam logic [2:0] S_ST_DONE = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [4:0]              k_q, k_d;
    logic [1:0]              mode_q, mode_d;
    logic [PIC_W_MB_LEN-1:0] x_q, x_d;
    logic [PIC_H_MB_LEN-1:0] y_q, y_d;
    logic [PIC_W_MB_LEN:0]   w_q, w_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              load_valid_q, load_valid_d;
    logic [DW-1:0]     load_data_q, load_data_d;
    logic              load_done_q, load_done_d;
    logic              store_done_q, store_done_d;
    logic              store_rden_q, store_rden_d;
    logic [4:0]        store_raddr_q, store_raddr_d;

    logic              mem_hs;
    logic [4:0]        n_beats;
    logic              last_beat;
    logic [ADDR_W-1:0] gen_addr;
    logic [4:0]        gen_raddr;

    assign mem_hs    = mem_req_q & mem_ack_i;
    assign n_beats   = beat_count(mode_q);
    assign last_beat = (k_q == n_beats - 5'd1);

    // Fed from next-state values so output registers load the address of
    // the word about to be issued.
    fetch_db_ext_addr_gen #(
        .PIC_W_MB_LEN (PIC_W_MB_LEN),
        .PIC_H_MB_LEN (PIC_H_MB_LEN),
        .ADDR_W       (ADDR_W),
        .Y_BASE       (Y_BASE),
        .U_BASE       (U_BASE),
        .V_BASE       (V_BASE)
    ) u_addr_gen (
        .mode_i  (mode_d),
        .k_i     (k_d[3:0]),
        .x_i     (x_d),
        .y_i     (y_d),
        .w_i     (w_d),
        .addr_o  (gen_addr),
        .raddr_o (gen_raddr)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        case (state_q)
            S_IDLE: begin
                if (load_en_i || store_en_i) begin
                    state_d = load_en_i ? S_LD_REQ : S_ST_RD;
                    k_d     = 5'd0;
                    mode_d  = load_en_i ? load_mode_i : store_mode_i;
                    x_d     = load_en_i ? load_x_i : store_x_i;
                    y_d     = load_en_i ? load_y_i : store_y_i;
                    w_d     = {1'b0, sys_total_x} + {{PIC_W_MB_LEN{1'b0}}, 1'b1};
                end
            end
            S_LD_REQ: begin
                // k reaches N after the last ack; the following gap cycle ends the load.
                if (mem_hs) begin
                    k_d = k_q + 5'd1;
                end else if (!mem_req_q && (k_q == n_beats)) begin
                    state_d = S_LD_DONE;
                end
            end
            S_LD_DONE: state_d = S_IDLE;
            S_ST_RD:   state_d = S_ST_CAP;
            S_ST_CAP:  state_d = S_ST_REQ;
            S_ST_REQ: begin
                if (mem_hs) begin
                    if (last_beat) begin
                        state_d = S_ST_DONE;
                    end else begin
                        k_d     = k_q + 5'd1;
                        state_d = S_ST_RD;
                    end
                end
            end
            S_ST_DONE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        load_data_d   = load_data_q;
        store_raddr_d = store_raddr_q;
        load_valid_d  = 1'b0;
        load_done_d   = 1'b0;
        store_done_d  = 1'b0;
        store_rden_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (state_d == S_LD_REQ) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = gen_addr;
                end else if (state_d == S_ST_RD) begin
                    store_rden_d  = 1'b1;
                    store_raddr_d = gen_raddr;
                end
            end
            S_LD_REQ: begin
                if (mem_hs) begin
                    mem_req_d    = 1'b0;
                    load_valid_d = 1'b1;
                    load_data_d  = mem_rdata_i;
                end else if (!mem_req_q) begin
                    if (state_d == S_LD_DONE) begin
                        load_done_d = 1'b1;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = gen_addr;
                    end
                end
            end
            S_ST_CAP: begin
                mem_wdata_d = store_rdata_i;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = gen_addr;
            end
            S_ST_REQ: begin
                if (mem_hs) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_d == S_ST_DONE) begin
                        store_done_d = 1'b1;
                    end else begin
                        store_rden_d  = 1'b1;
                        store_raddr_d = gen_raddr;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            mode_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            w_q           <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            load_valid_q  <= 1'b0;
            load_data_q   <= '0;
            load_done_q   <= 1'b0;
            store_done_q  <= 1'b0;
            store_rden_q  <= 1'b0;
            store_raddr_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            mode_q        <= mode_d;
            x_q           <= x_d;
            y_q           <= y_d;
            w_q           <= w_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            load_valid_q  <= load_valid_d;
            load_data_q   <= load_data_d;
            load_done_q   <= load_done_d;
            store_done_q  <= store_done_d;
            store_rden_q  <= store_rden_d;
            store_raddr_q <= store_raddr_d;
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign load_valid_o  = load_valid_q;
    assign load_data_o   = load_data_q;
    assign load_done_o   = load_done_q;
    assign store_done_o  = store_done_q;
    assign store_rden_o  = store_rden_q;
    assign store_raddr_o = store_raddr_q;

endmodule

// File: tb/tb_fetch_db_ext_mem.sv
// Bench for fetch_db_ext_mem: random-latency memory and store-buffer
// responders, a per-request reference model of the word sequence, and checks.
module tb_fetch_db_ext_mem;

    localparam int XW = 8;
    localparam int YW = 8;
    localparam int DW = 128;
    localparam int AW = 24;
    localparam longint YB = 64'h0;
    localparam longint UB = 64'h100000;
    localparam longint VB = 64'h180000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [XW-1:0] sys_total_x = '0;
    logic          load_en_i = 1'b0;
    logic [XW-1:0] load_x_i = '0;
    logic [YW-1:0] load_y_i = '0;
    logic [1:0]    load_mode_i = '0;
    logic          load_done_o;
    logic          load_valid_o;
    logic [DW-1:0] load_data_o;
    logic          store_en_i = 1'b0;
    logic [XW-1:0] store_x_i = '0;
    logic [YW-1:0] store_y_i = '0;
    logic [1:0]    store_mode_i = '0;
    logic          store_done_o;
    logic          store_rden_o;
    logic [4:0]    store_raddr_o;
    logic [DW-1:0] store_rdata_i = '0;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    fetch_db_ext_mem dut (
        .clk           (clk),
        .rst           (rst),
        .sys_total_x   (sys_total_x),
        .load_en_i     (load_en_i),
        .load_x_i      (load_x_i),
        .load_y_i      (load_y_i),
        .load_mode_i   (load_mode_i),
        .load_done_o   (load_done_o),
        .load_valid_o  (load_valid_o),
        .load_data_o   (load_data_o),
        .store_en_i    (store_en_i),
        .store_x_i     (store_x_i),
        .store_y_i     (store_y_i),
        .store_mode_i  (store_mode_i),
        .store_done_o  (store_done_o),
        .store_rden_o  (store_rden_o),
        .store_raddr_o (store_raddr_o),
        .store_rdata_i (store_rdata_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t          exp_rd[$];
    txn_t          exp_wr[$];
    logic [4:0]    exp_raddr[$];
    logic [DW-1:0] exp_ld[$];
    logic [AW-1:0] obs_addr[$];
    logic          obs_we[$];
    logic [DW-1:0] sbuf[24];

    int n_checks = 0;
    int n_fail = 0;
    int ld_done_cnt = 0;
    int st_done_cnt = 0;
    int n_reads = 0;
    bit hold_ack = 1'b0;
    bit force_ack = 1'b0;

    task automatic check_eq(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_buf();
        for (int i = 0; i < 24; i++) sbuf[i] = rnd128();
    endtask

    // Enumerate the blocks a request touches (plane 0=Y,1=U,2=V) and push the expected words.
    task automatic model_push(input bit st, input int x, input int y, input int mode, input int w);
        int n;
        int pl[16];
        int rr[16];
        int cc[16];
        int ra[16];
        longint a;
        txn_t t;
        n = 0;
        case (mode)
            0: for (int c = 0; c < 4; c++) begin
                pl[n] = 0; rr[n] = 3; cc[n] = c; ra[n] = 12 + c; n++;
            end
            1: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
                pl[n] = 0; rr[n] = r; cc[n] = c; ra[n] = 4 * r + c; n++;
            end
            2: for (int p = 0; p < 2; p++) for (int c = 0; c < 2; c++) begin
                pl[n] = p + 1; rr[n] = 1; cc[n] = c; ra[n] = 16 + 4 * p + 2 + c; n++;
            end
            default: for (int p = 0; p < 2; p++) for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
                pl[n] = p + 1; rr[n] = r; cc[n] = c; ra[n] = 16 + 4 * p + 2 * r + c; n++;
            end
        endcase
        for (int i = 0; i < n; i++) begin
            if (pl[i] == 0) a = YB + ((longint'(y) * 4 + rr[i]) * w + x) * 4 + cc[i];
            else a = ((pl[i] == 1) ? UB : VB) + ((longint'(y) * 2 + rr[i]) * w + x) * 2 + cc[i];
            t.addr = a[AW-1:0];
            t.wdata = st ? sbuf[ra[i]] : '0;
            if (st) begin
                exp_wr.push_back(t);
                exp_raddr.push_back(5'(ra[i]));
            end else begin
                exp_rd.push_back(t);
            end
        end
    endtask

    // Memory / store-buffer responder and per-cycle compare process.
    bit            busy = 1'b0;
    int            wcnt = 0;
    bit            req_p = 1'b0;
    bit            ack_p = 1'b0;
    bit            rden_p = 1'b0;
    logic [4:0]    raddr_p = '0;
    logic [153:0]  bus_p = '0;
    txn_t          e;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack_i = force_ack;
            mem_rdata_i = rnd128();
            busy = 1'b0;
            req_p = 1'b0;
            ack_p = 1'b0;
            rden_p = 1'b0;
        end else begin
            store_rdata_i = rden_p ? sbuf[raddr_p] : rnd128();
            rden_p = store_rden_o;
            raddr_p = store_raddr_o;

            if (req_p && !ack_p)
                check_eq("mem_hold_while_stalled", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, bus_p);
            if (req_p && ack_p)
                check_eq("req_gap_after_ack", mem_req_o, 1'b0);

            if (store_rden_o) begin
                if (exp_raddr.size() == 0) check_eq("rden_unexpected", 1'b1, 1'b0);
                else check_eq("store_raddr", store_raddr_o, exp_raddr.pop_front());
            end
            if (load_valid_o) begin
                if (exp_ld.size() == 0) check_eq("load_valid_unexpected", 1'b1, 1'b0);
                else check_eq("load_data", load_data_o, exp_ld.pop_front());
            end
            if (load_done_o) begin
                ld_done_cnt++;
                check_eq("load_done_after_beats", {load_valid_o, 8'(exp_ld.size()), 8'(exp_rd.size())}, 17'd0);
            end
            if (store_done_o) begin
                st_done_cnt++;
                check_eq("store_done_after_writes", {8'(exp_wr.size()), 8'(exp_raddr.size())}, 16'd0);
            end

            mem_rdata_i = rnd128();
            if (mem_req_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = $urandom_range(0, 3);
                end
                if (wcnt == 0 && !hold_ack) begin
                    mem_ack_i = 1'b1;
                    busy = 1'b0;
                    obs_addr.push_back(mem_addr_o);
                    obs_we.push_back(mem_we_o);
                    if (mem_we_o) begin
                        if (exp_wr.size() == 0) check_eq("write_unexpected", 1'b1, 1'b0);
                        else begin
                            e = exp_wr.pop_front();
                            check_eq("write_addr", mem_addr_o, e.addr);
                            check_eq("write_data", mem_wdata_o, e.wdata);
                        end
                    end else begin
                        n_reads++;
                        if (exp_rd.size() == 0) check_eq("read_unexpected", 1'b1, 1'b0);
                        else begin
                            e = exp_rd.pop_front();
                            check_eq("read_addr", mem_addr_o, e.addr);
                        end
                        exp_ld.push_back(mem_rdata_i);
                    end
                end else begin
                    mem_ack_i = 1'b0;
                    if (wcnt > 0) wcnt--;
                end
            end else begin
                busy = 1'b0;
                mem_ack_i = ($urandom_range(0, 3) == 0);
            end
            req_p = mem_req_o;
            ack_p = mem_ack_i;
            bus_p = {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit st, input string name);
        int t;
        t = 0;
        while (!(st ? store_done_o : load_done_o) && t < 400) begin
            tick();
            t++;
        end
        check_eq(name, (t < 400), 1'b1);
    endtask

    task automatic run_req(input bit st, input int x, input int y, input int mode, input bit scramble);
        int w;
        int ld0;
        int sd0;
        w = int'(sys_total_x) + 1;
        ld0 = ld_done_cnt;
        sd0 = st_done_cnt;
        if (st) fill_buf();
        model_push(st, x, y, mode, w);
        if (st) begin
            store_x_i = XW'(x); store_y_i = YW'(y); store_mode_i = 2'(mode); store_en_i = 1'b1;
        end else begin
            load_x_i = XW'(x); load_y_i = YW'(y); load_mode_i = 2'(mode); load_en_i = 1'b1;
        end
        tick();
        if (scramble) begin
            load_x_i = XW'($urandom); load_y_i = YW'($urandom); load_mode_i = 2'($urandom);
            store_x_i = XW'($urandom); store_y_i = YW'($urandom); store_mode_i = 2'($urandom);
            sys_total_x = XW'($urandom);
        end
        wait_done(st, st ? "store_done_timeout" : "load_done_timeout");
        if (st) store_en_i = 1'b0;
        else load_en_i = 1'b0;
        repeat (2) tick();
        check_eq("queues_drained", 32'(exp_rd.size() + exp_wr.size() + exp_raddr.size() + exp_ld.size()), 32'd0);
        check_eq(st ? "store_done_count" : "load_done_count", 32'(st ? st_done_cnt - sd0 : ld_done_cnt - ld0), 32'd1);
    endtask

    task automatic clear_model();
        exp_rd.delete(); exp_wr.delete(); exp_raddr.delete(); exp_ld.delete();
        obs_addr.delete(); obs_we.delete();
    endtask

    initial begin
        int t;
        int r0;
        int l0;
        int s0;
        bit st;

        repeat (3) tick();
        check_eq("reset_outputs", |{load_done_o, load_valid_o, load_data_o, store_done_o, store_rden_o,
                 store_raddr_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        sys_total_x = 8'd9;
        clear_model();
        run_req(1'b0, 3, 2, 0, 1'b0);
        check_eq("ybot_addr0", obs_addr[0], 24'd452);
        check_eq("ybot_addr3", obs_addr[3], 24'd455);
        check_eq("ybot_nwords", 32'(obs_addr.size()), 32'd4);

        sys_total_x = 8'd9;
        clear_model();
        run_req(1'b0, 3, 2, 2, 1'b1);
        check_eq("uvbot_addr0", obs_addr[0], 24'h100000 + 24'd106);
        check_eq("uvbot_addr1", obs_addr[1], 24'h100000 + 24'd107);
        check_eq("uvbot_addr2", obs_addr[2], 24'h180000 + 24'd106);
        check_eq("uvbot_addr3", obs_addr[3], 24'h180000 + 24'd107);

        sys_total_x = 8'd9;
        clear_model();
        run_req(1'b1, 0, 0, 1, 1'b1);
        check_eq("yfull_store_addr5", obs_addr[5], 24'd41);
        check_eq("yfull_store_addr15", obs_addr[15], 24'd123);

        sys_total_x = 8'd9;
        clear_model();
        run_req(1'b1, 9, 1, 3, 1'b0);
        check_eq("uvfull_store_addr0", obs_addr[0], 24'h100000 + 24'd58);
        check_eq("uvfull_store_addr7", obs_addr[7], 24'h180000 + 24'd79);

        // Back-to-back loads with enable held through the first done.
        sys_total_x = 8'd9;
        clear_model();
        r0 = n_reads;
        l0 = ld_done_cnt;
        model_push(1'b0, 3, 2, 0, 10);
        load_x_i = 8'd3; load_y_i = 8'd2; load_mode_i = 2'b00; load_en_i = 1'b1;
        wait_done(1'b0, "b2b_first_done_timeout");
        tick();
        model_push(1'b0, 3, 2, 2, 10);
        load_mode_i = 2'b10;
        wait_done(1'b0, "b2b_second_done_timeout");
        load_en_i = 1'b0;
        repeat (10) tick();
        check_eq("b2b_reads", 32'(n_reads - r0), 32'd8);
        check_eq("b2b_dones", 32'(ld_done_cnt - l0), 32'd2);

        // Load and store both requested in IDLE: load is serviced first.
        clear_model();
        fill_buf();
        model_push(1'b0, 5, 4, 3, 10);
        model_push(1'b1, 2, 7, 2, 10);
        load_x_i = 8'd5; load_y_i = 8'd4; load_mode_i = 2'b11; load_en_i = 1'b1;
        store_x_i = 8'd2; store_y_i = 8'd7; store_mode_i = 2'b10; store_en_i = 1'b1;
        tick();
        wait_done(1'b0, "both_load_done_timeout");
        load_en_i = 1'b0;
        wait_done(1'b1, "both_store_done_timeout");
        store_en_i = 1'b0;
        repeat (2) tick();
        check_eq("both_first_is_read", obs_we[0], 1'b0);
        check_eq("both_ninth_is_write", obs_we[8], 1'b1);

        // Reset during a stalled write with an ack in the reset cycle.
        clear_model();
        fill_buf();
        model_push(1'b1, 1, 1, 1, 10);
        hold_ack = 1'b1;
        store_x_i = 8'd1; store_y_i = 8'd1; store_mode_i = 2'b01; store_en_i = 1'b1;
        t = 0;
        while (!(mem_req_o && mem_we_o) && t < 50) begin
            tick();
            t++;
        end
        check_eq("reach_st_req_timeout", (t < 50), 1'b1);
        rst = 1'b1;
        force_ack = 1'b1;
        store_en_i = 1'b0;
        s0 = st_done_cnt;
        tick();
        check_eq("midreset_outputs", |{load_done_o, load_valid_o, load_data_o, store_done_o, store_rden_o,
                 store_raddr_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, 1'b0);
        rst = 1'b0;
        force_ack = 1'b0;
        hold_ack = 1'b0;
        clear_model();
        repeat (5) tick();
        check_eq("midreset_no_store_done", 32'(st_done_cnt - s0), 32'd0);
        run_req(1'b1, 4, 3, 3, 1'b0);

        for (int i = 0; i < 14; i++) begin
            sys_total_x = XW'($urandom_range(0, 255));
            st = 1'($urandom);
            clear_model();
            run_req(st, $urandom_range(0, int'(sys_total_x)), $urandom_range(0, 255),
                    $urandom_range(0, 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
